pipe_stage_chain: RTL and testbench



---
 rtl/pipe_stage_chain.sv | 116 +++++++++++
 tb/tb_pipe_stage_chain.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers with per-stage valid bits, valid/ready
// handshake, global stall, per-stage flush, registered occupancy and a squash counter.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             stall,
  input  logic [DEPTH-1:0] flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] enter;
  logic [DEPTH-1:0] kill;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             advance;
  logic             hole;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] kill_n;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_d;

  assign advance = ~stall;

  // Stage i can take an item when the sink is ready or any stage at or
  // beyond i is empty; this is the unrolled form of ~valid[i] | rdy[i+1].
  always_comb begin
    hole       = 1'b0;
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hole   = hole | ~valid_q[i];
      rdy[i] = out_ready | hole;
    end
  end

  assign in_ready  = rdy[0] & advance;
  // A stalled chain ignores flush, so the head item stays visible.
  assign out_valid = valid_q[DEPTH-1] & ~(flush[DEPTH-1] & advance);
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    move    = '0;
    enter   = '0;
    kill    = '0;
    valid_d = valid_q;
    if (advance) begin
      for (int i = 0; i < DEPTH; i++) begin
        move[i] = valid_q[i] & rdy[i+1];
        kill[i] = valid_q[i] & flush[i];
      end
      enter[0] = in_valid & rdy[0];
      // A flushed source dies in flight; the destination's own flush bit
      // only applies to what it already held.
      for (int i = 1; i < DEPTH; i++) begin
        enter[i] = move[i-1] & ~flush[i-1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        valid_d[i] = enter[i] | (valid_q[i] & ~move[i] & ~flush[i]);
      end
    end
  end

  always_comb begin
    occ_d  = '0;
    kill_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d  = occ_d + OCC_W'(valid_d[i]);
      kill_n = kill_n + OCC_W'(kill[i]);
    end
  end

  assign cnt_sum = SUM_W'(squash_cnt) + SUM_W'(kill_n);
  assign cnt_d   = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      occupancy  <= '0;
      squash_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (advance) begin
      valid_q    <= valid_d;
      occupancy  <= occ_d;
      squash_cnt <= cnt_d;
      if (enter[0]) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (enter[i]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus random traffic, checked each
// cycle against a slot-level reference model and an in-order expected queue.
module tb_pipe_stage_chain;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int OCC_W  = 3;
  localparam int SQ_MAX = 65535;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             stall;
  logic [DEPTH-1:0] flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] squash_cnt;

  logic             s_in_valid;
  logic [7:0]       s_in_data;
  logic             s_in_ready;
  logic             s_stall;
  logic [DEPTH-1:0] s_flush;
  logic             s_out_valid;
  logic [7:0]       s_out_data;
  logic             s_out_ready;
  logic [OCC_W-1:0] s_occupancy;
  logic [1:0]       s_squash_cnt;

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy), .squash_cnt(squash_cnt)
  );

  pipe_stage_chain #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .stall(s_stall), .flush(s_flush), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(s_out_ready), .occupancy(s_occupancy), .squash_cnt(s_squash_cnt)
  );

  // Reference model: which slots hold an item, and what each item is.
  bit               m_valid [DEPTH];
  logic [WIDTH-1:0] m_data  [DEPTH];
  int               m_sq;
  int               m_occ;
  logic [WIDTH-1:0] exp_q [$];

  int vectors, miscompares;
  int step_no, first_acc, first_ov, n_out, max_occ;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit any_empty_from(input int i);
    for (int j = i; j < DEPTH; j++) if (!m_valid[j]) return 1'b1;
    return 1'b0;
  endfunction

  // An item advances when the sink takes items or some slot ahead of it is empty.
  function automatic bit m_advances(input int i);
    return m_valid[i] && (out_ready || any_empty_from(i + 1));
  endfunction

  function automatic bit m_in_ready();
    return !stall && (out_ready || any_empty_from(0));
  endfunction

  function automatic bit m_out_valid();
    return m_valid[DEPTH-1] && !(flush[DEPTH-1] && !stall);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_sq  = 0;
    m_occ = 0;
    exp_q.delete();
  endtask

  task automatic drop(input logic [WIDTH-1:0] v);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_q[k] == v) begin
        exp_q.delete(k);
        break;
      end
    end
  endtask

  // One clock cycle: compare at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit               nv [DEPTH];
    logic [WIDTH-1:0] nd [DEPTH];
    bit               lv [DEPTH];
    bit               acc;
    @(negedge clk);
    check("in_ready", in_ready, m_in_ready());
    check("out_valid", out_valid, m_out_valid());
    if (m_out_valid()) check("out_data", out_data, m_data[DEPTH-1]);
    check("occupancy", occupancy, m_occ);
    check("squash_cnt", squash_cnt, m_sq);
    if (out_valid === 1'b1 && first_ov < 0) first_ov = step_no;
    if (occupancy > max_occ) max_occ = occupancy;
    for (int i = 0; i < DEPTH; i++) begin
      nv[i] = 1'b0;
      nd[i] = m_data[i];
    end
    if (!stall) begin
      acc = in_valid && m_in_ready();
      for (int i = 0; i < DEPTH; i++) lv[i] = m_advances(i);
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i]) begin
          if (flush[i]) begin
            if (m_sq < SQ_MAX) m_sq++;
            drop(m_data[i]);
          end else if (lv[i] && i == DEPTH - 1) begin
            n_out++;
            if (exp_q.size() == 0) check("order_empty", 1, 0);
            else check("order", out_data, exp_q.pop_front());
          end else if (lv[i]) begin
            nv[i+1] = 1'b1;
            nd[i+1] = m_data[i];
          end else begin
            nv[i] = 1'b1;
          end
        end
      end
      if (acc) begin
        nv[0] = 1'b1;
        nd[0] = in_data;
        exp_q.push_back(in_data);
        if (first_acc < 0) first_acc = step_no;
      end
    end
    @(posedge clk);
    #1;
    step_no++;
    if (!stall) begin
      m_occ = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = nv[i];
        m_data[i]  = nd[i];
        m_occ += int'(nv[i]);
      end
    end
  endtask

  initial begin
    int sq_before, seq, waited;
    vectors = 0; miscompares = 0; step_no = 0; n_out = 0; max_occ = 0;
    first_acc = -1; first_ov = -1;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_stall = 1'b0; s_flush = '0; s_out_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_squash_cnt", squash_cnt, 0);
    rst = 1'b0;

    // Back-to-back stream of 1..8 into an empty chain.
    for (int v = 1; v <= 8; v++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(v);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    check("latency_steps", first_ov - first_acc, DEPTH);
    check("stream_count", n_out, 8);
    check("stream_max_occ", max_occ, DEPTH);

    // Backpressure: fill, then one cycle of out_ready.
    out_ready = 1'b0;
    for (int v = 'h21; v <= 'h24; v++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(v);
      step();
    end
    in_data = 'h25;
    step();
    check("full_occupancy", occupancy, 4);
    check("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();
    check("bp_occupancy", occupancy, 4);
    check("bp_head", out_data, 'h22);

    // Branch squash of the two youngest stages while E waits at the input.
    flush    = 4'b0011;
    in_valid = 1'b1;
    in_data  = 'h26;
    sq_before = m_sq;
    step();
    flush = '0;
    check("squash_two", squash_cnt, sq_before + 2);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();

    // Stall mid-stream with every flush bit set.
    for (int v = 'h30; v < 'h33; v++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(v);
      step();
    end
    sq_before = m_sq;
    stall = 1'b1;
    flush = 4'b1111;
    in_data = 'h33;
    repeat (3) step();
    check("stall_squash", squash_cnt, sq_before);
    stall = 1'b0;
    flush = '0;
    for (int v = 'h33; v < 'h36; v++) begin
      in_data = WIDTH'(v);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // Flush the head item while the sink is ready.
    in_valid = 1'b1;
    in_data  = 'h40;
    step();
    in_valid = 1'b0;
    waited = 0;
    while (!m_valid[DEPTH-1] && waited < 10) begin
      step();
      waited++;
    end
    check("head_reached", int'(m_valid[DEPTH-1]), 1);
    sq_before = m_sq;
    flush = 4'b1000;
    step();
    flush = '0;
    check("head_squash", squash_cnt, sq_before + 1);
    step();

    // Random traffic.
    seq = 'h100;
    for (int n = 0; n < 400; n++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = {16'($urandom), 16'(seq)};
      seq++;
      out_ready = $urandom_range(0, 9) < 7;
      stall     = $urandom_range(0, 7) == 0;
      flush     = ($urandom_range(0, 5) == 0) ? DEPTH'($urandom) : '0;
      step();
    end
    in_valid = 1'b0; stall = 1'b0; flush = '0; out_ready = 1'b1;
    repeat (6) step();
    check("drain_empty", exp_q.size(), 0);

    // Asynchronous reset with three items in flight.
    out_ready = 1'b0;
    for (int v = 'h50; v < 'h53; v++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(v);
      step();
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_occupancy", occupancy, 0);
    check("arst_squash_cnt", squash_cnt, 0);
    check("arst_in_ready", in_ready, 1);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step();

    // Saturation of a 2-bit squash counter over five single-item flushes.
    for (int k = 0; k < 5; k++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'(k + 1);
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      s_flush    = 4'b0001;
      @(posedge clk);
      #1;
      s_flush = '0;
      check("sat_squash_cnt", s_squash_cnt, (k + 1 > 3) ? 3 : k + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
